// File: rtl/control_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lc3b_types (package)
// Description : Shared LC-3b types for the control sequencer: opcodes, mux
//               selects, the per-stage control word, sequencer FSM states and
//               a micro-op count helper.
// Revision    : 1.0 - initial release
// ============================================================================
package lc3b_types;

    // This core's encoding places SHF at 0x4; 0xD is reserved.
    typedef enum logic [3:0] {
        op_br   = 4'h0,
        op_add  = 4'h1,
        op_ldb  = 4'h2,
        op_stb  = 4'h3,
        op_shf  = 4'h4,
        op_and  = 4'h5,
        op_ldr  = 4'h6,
        op_str  = 4'h7,
        op_rti  = 4'h8,
        op_not  = 4'h9,
        op_ldi  = 4'hA,
        op_sti  = 4'hB,
        op_jmp  = 4'hC,
        op_rsv  = 4'hD,
        op_lea  = 4'hE,
        op_trap = 4'hF
    } lc3b_opcode;

    typedef enum logic [2:0] {
        alu_add  = 3'd0,
        alu_and  = 3'd1,
        alu_not  = 3'd2,
        alu_pass = 3'd3,
        alu_sll  = 3'd4,
        alu_srl  = 3'd5,
        alu_sra  = 3'd6
    } lc3b_aluop;

    // Second ALU operand: register sr2, imm5, offset6<<1, imm4 (shift amount)
    typedef enum logic [1:0] {
        alumux_sr2     = 2'd0,
        alumux_imm5    = 2'd1,
        alumux_offset6 = 2'd2,
        alumux_imm4    = 2'd3
    } lc3b_alumux_sel;

    // sr2 register select: ir[2:0] or the dest field ir[11:9] (store data)
    typedef enum logic [0:0] {
        sr2mux_sel_sr2  = 1'b0,
        sr2mux_sel_dest = 1'b1
    } lc3b_sr2mux_sel;

    typedef enum logic [0:0] {
        regfile_data_mux_sel_alu = 1'b0,
        regfile_data_mux_sel_mdr = 1'b1
    } lc3b_regfile_data_mux_sel;

    typedef enum logic [0:0] {
        cc_gen_sel_alu = 1'b0,
        cc_gen_sel_mdr = 1'b1
    } lc3b_cc_gen_sel;

    typedef enum logic [0:0] {
        lc3b_data_memory_addr_mux_sel_alu = 1'b0,
        lc3b_data_memory_addr_mux_sel_mdr = 1'b1
    } lc3b_data_memory_addr_mux_sel;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } lc3b_seq_state;

    typedef struct packed {
        lc3b_opcode                   opcode;
        lc3b_aluop                    aluop;
        lc3b_alumux_sel               alumux_sel;
        lc3b_sr2mux_sel               sr2mux_sel;
        lc3b_regfile_data_mux_sel     regfile_data_mux_sel;
        lc3b_cc_gen_sel               cc_gen_sel;
        lc3b_data_memory_addr_mux_sel data_memory_addr_mux_sel;
        logic                         regfile_load;
        logic                         cc_load;
        logic                         branch_enable;
        logic                         data_memory_read;
        logic                         data_memory_write_enable;
        logic [1:0]                   data_memory_byte_sel;
        logic                         internal_mdr_load;
        logic [2:0]                   dr;
        logic [2:0]                   sr1;
        logic [2:0]                   sr2;
        logic [5:0]                   imm6;
    } lc3b_control_word;

    // Number of micro-ops an opcode expands to
    function automatic int unsigned uop_count(lc3b_opcode op, logic indirect);
        if (indirect && (op == op_ldi || op == op_sti)) begin
            return 2;
        end
        return 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/control_sequencer_uop.sv
`default_nettype none
// ============================================================================
// Module      : uop_rom
// Description : Combinational micro-op decode. Maps opcode, operand bits and
//               micro-op index to a control word. Unsupported opcodes and
//               out-of-range indices decode to the all-zero word.
// Revision    : 1.0 - initial release
// ============================================================================
module uop_rom
    import lc3b_types::*;
#(
    parameter int IR_WIDTH        = 16,
    parameter int MAX_UOPS        = 2,
    parameter int ENABLE_INDIRECT = 1
) (
    input  lc3b_opcode                    opcode_i,
    input  logic [IR_WIDTH-5:0]           ir_i,
    input  logic [$clog2(MAX_UOPS)-1:0]   uop_idx_i,
    output lc3b_control_word              cw_o
);

    localparam int UIW = $clog2(MAX_UOPS);

    lc3b_control_word base;

    // Decode: register/immediate fields are common, control bits per opcode
    always_comb begin
        base        = '0;
        base.opcode = opcode_i;
        base.dr     = ir_i[11:9];
        base.sr1    = ir_i[8:6];
        base.sr2    = ir_i[2:0];
        base.imm6   = ir_i[5:0];

        cw_o = '0;
        case (opcode_i)
            op_add, op_and: begin
                cw_o              = base;
                cw_o.aluop        = (opcode_i == op_add) ? alu_add : alu_and;
                cw_o.alumux_sel   = ir_i[5] ? alumux_imm5 : alumux_sr2;
                cw_o.regfile_load = 1'b1;
                cw_o.cc_load      = 1'b1;
            end
            op_not: begin
                cw_o              = base;
                cw_o.aluop        = alu_not;
                cw_o.regfile_load = 1'b1;
                cw_o.cc_load      = 1'b1;
            end
            op_shf: begin
                cw_o              = base;
                cw_o.aluop        = !ir_i[4] ? alu_sll : (ir_i[5] ? alu_sra : alu_srl);
                cw_o.alumux_sel   = alumux_imm4;
                cw_o.regfile_load = 1'b1;
                cw_o.cc_load      = 1'b1;
            end
            op_ldr: begin
                cw_o                      = base;
                cw_o.aluop                = alu_add;
                cw_o.alumux_sel           = alumux_offset6;
                cw_o.data_memory_read     = 1'b1;
                cw_o.data_memory_byte_sel = 2'b11;
                cw_o.regfile_data_mux_sel = regfile_data_mux_sel_mdr;
                cw_o.cc_gen_sel           = cc_gen_sel_mdr;
                cw_o.regfile_load         = 1'b1;
                cw_o.cc_load              = 1'b1;
            end
            op_str: begin
                cw_o                          = base;
                cw_o.aluop                    = alu_add;
                cw_o.alumux_sel               = alumux_offset6;
                cw_o.sr2mux_sel               = sr2mux_sel_dest;
                cw_o.data_memory_write_enable = 1'b1;
                cw_o.data_memory_byte_sel     = 2'b11;
            end
            op_br: begin
                cw_o               = base;
                cw_o.branch_enable = 1'b1;
            end
            op_ldi, op_sti: begin
                if (ENABLE_INDIRECT != 0) begin
                    if (uop_idx_i == '0) begin
                        // Pointer fetch: base + offset6<<1 into the internal MDR
                        cw_o                      = base;
                        cw_o.aluop                = alu_add;
                        cw_o.alumux_sel           = alumux_offset6;
                        cw_o.data_memory_read     = 1'b1;
                        cw_o.data_memory_byte_sel = 2'b11;
                        cw_o.internal_mdr_load    = 1'b1;
                    end else if (uop_idx_i == UIW'(1)) begin
                        cw_o                          = base;
                        cw_o.data_memory_addr_mux_sel = lc3b_data_memory_addr_mux_sel_mdr;
                        cw_o.data_memory_byte_sel     = 2'b11;
                        if (opcode_i == op_ldi) begin
                            cw_o.data_memory_read     = 1'b1;
                            cw_o.regfile_data_mux_sel = regfile_data_mux_sel_mdr;
                            cw_o.cc_gen_sel           = cc_gen_sel_mdr;
                            cw_o.regfile_load         = 1'b1;
                            cw_o.cc_load              = 1'b1;
                        end else begin
                            cw_o.sr2mux_sel               = sr2mux_sel_dest;
                            cw_o.data_memory_write_enable = 1'b1;
                        end
                    end
                end
            end
            default: cw_o = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : control_sequencer
// Description : Instruction handshake, micro-op sequencing FSM for indirect
//               loads/stores, and the registered control-word pipeline with
//               stall and partial flush.
// Revision    : 1.0 - initial release
// ============================================================================
module control_sequencer
    import lc3b_types::*;
#(
    parameter int IR_WIDTH        = 16,
    parameter int STAGES          = 4,
    parameter int MAX_UOPS        = 2,
    parameter int ENABLE_INDIRECT = 1,
    parameter int FLUSH_DEPTH     = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [IR_WIDTH-1:0]           ir_in,
    input  logic                          ir_valid,
    output logic                          ir_ready,
    input  logic                          stall,
    input  logic                          flush,
    output lc3b_control_word              ctrl_stage [STAGES],
    output logic                          uop_busy,
    output logic [$clog2(MAX_UOPS)-1:0]   uop_index
);

    localparam int UIW = $clog2(MAX_UOPS);
    localparam logic INDIRECT = (ENABLE_INDIRECT != 0);

    lc3b_seq_state          state_q;
    logic [UIW-1:0]         uop_idx_q;
    logic [IR_WIDTH-1:0]    ir_q;
    lc3b_control_word       stage_q [STAGES];

    logic                   accept;
    logic                   issue_d;
    logic                   seq_last;
    logic [IR_WIDTH-1:0]    rom_ir;
    logic [UIW-1:0]         rom_idx;
    lc3b_opcode             rom_op;
    lc3b_opcode             in_op;
    lc3b_opcode             held_op;
    lc3b_control_word       rom_cw;
    lc3b_control_word       stage0_d;

    assign uop_busy  = (state_q == SEQ);
    assign uop_index = uop_idx_q;
    assign ir_ready  = !stall && !uop_busy && !reset;
    assign accept    = ir_valid && ir_ready && !flush;

    assign in_op    = lc3b_opcode'(ir_in[IR_WIDTH-1 -: 4]);
    assign held_op  = lc3b_opcode'(ir_q[IR_WIDTH-1 -: 4]);
    assign seq_last = (uop_idx_q == UIW'(uop_count(held_op, INDIRECT) - 1));

    // Decoder source: the incoming word when idle, the latched word mid-sequence
    always_comb begin
        rom_ir  = ir_in;
        rom_idx = '0;
        issue_d = accept;
        if (state_q == SEQ) begin
            rom_ir  = ir_q;
            rom_idx = uop_idx_q;
            issue_d = !stall && !flush;
        end
        rom_op   = lc3b_opcode'(rom_ir[IR_WIDTH-1 -: 4]);
        stage0_d = issue_d ? rom_cw : '0;
    end

    uop_rom #(
        .IR_WIDTH        (IR_WIDTH),
        .MAX_UOPS        (MAX_UOPS),
        .ENABLE_INDIRECT (ENABLE_INDIRECT)
    ) u_uop_rom (
        .opcode_i  (rom_op),
        .ir_i      (rom_ir[IR_WIDTH-5:0]),
        .uop_idx_i (rom_idx),
        .cw_o      (rom_cw)
    );

    // Sequencer FSM and control-word pipeline
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            uop_idx_q <= '0;
            ir_q      <= '0;
            for (int k = 0; k < STAGES; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            // Stage 0 is always among the flushed stages; stage0_d is a bubble on flush
            if (flush || !stall) begin
                stage_q[0] <= stage0_d;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (flush && (k < FLUSH_DEPTH)) begin
                    stage_q[k] <= '0;
                end else if (!stall) begin
                    stage_q[k] <= stage_q[k-1];
                end
            end

            if (flush) begin
                state_q   <= IDLE;
                uop_idx_q <= '0;
            end else if (!stall) begin
                case (state_q)
                    IDLE: begin
                        if (accept && (uop_count(in_op, INDIRECT) > 1)) begin
                            state_q   <= SEQ;
                            uop_idx_q <= UIW'(1);
                            ir_q      <= ir_in;
                        end
                    end
                    SEQ: begin
                        if (seq_last) begin
                            state_q   <= IDLE;
                            uop_idx_q <= '0;
                        end else begin
                            uop_idx_q <= uop_idx_q + UIW'(1);
                        end
                    end
                    default: begin
                        state_q   <= IDLE;
                        uop_idx_q <= '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            ctrl_stage[k] = stage_q[k];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_control_sequencer
// Description : Directed self-checking bench for control_sequencer, with a
//               second instance built without indirect sequencing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_control_sequencer;
    import lc3b_types::*;

    logic             clk = 1'b0;
    logic             reset;
    logic [15:0]      ir_in;
    logic             ir_valid;
    logic             stall;
    logic             flush;
    logic             ir_ready, ir_ready_ni;
    logic             uop_busy, uop_busy_ni;
    logic [0:0]       uop_index, uop_index_ni;
    lc3b_control_word ctrl    [4];
    lc3b_control_word ctrl_ni [4];

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    control_sequencer #(.ENABLE_INDIRECT(1)) dut (
        .clk(clk), .reset(reset), .ir_in(ir_in), .ir_valid(ir_valid),
        .ir_ready(ir_ready), .stall(stall), .flush(flush),
        .ctrl_stage(ctrl), .uop_busy(uop_busy), .uop_index(uop_index)
    );

    control_sequencer #(.ENABLE_INDIRECT(0)) dut_ni (
        .clk(clk), .reset(reset), .ir_in(ir_in), .ir_valid(ir_valid),
        .ir_ready(ir_ready_ni), .stall(stall), .flush(flush),
        .ctrl_stage(ctrl_ni), .uop_busy(uop_busy_ni), .uop_index(uop_index_ni)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        ir_valid = 1'b0;
        repeat (4) tick();
    endtask

    // Hand-filled opcode and register/immediate fields of an expected word
    function automatic lc3b_control_word fld(lc3b_opcode op, logic [2:0] dr,
                                             logic [2:0] s1, logic [2:0] s2,
                                             logic [5:0] imm);
        lc3b_control_word w;
        w = '0;
        w.opcode = op; w.dr = dr; w.sr1 = s1; w.sr2 = s2; w.imm6 = imm;
        return w;
    endfunction

    function automatic lc3b_control_word exp_add();
        lc3b_control_word e;
        e = fld(op_add, 3'd1, 3'd2, 3'd3, 6'h03);
        e.aluop = alu_add; e.regfile_load = 1'b1; e.cc_load = 1'b1;
        return e;
    endfunction

    function automatic lc3b_control_word exp_ind0(lc3b_opcode op);
        lc3b_control_word e;
        e = fld(op, 3'd0, 3'd1, 3'd2, 6'h02);
        e.alumux_sel = alumux_offset6; e.data_memory_read = 1'b1;
        e.data_memory_byte_sel = 2'b11; e.internal_mdr_load = 1'b1;
        return e;
    endfunction

    function automatic lc3b_control_word exp_ldi1();
        lc3b_control_word e;
        e = fld(op_ldi, 3'd0, 3'd1, 3'd2, 6'h02);
        e.data_memory_addr_mux_sel = lc3b_data_memory_addr_mux_sel_mdr;
        e.data_memory_read = 1'b1; e.data_memory_byte_sel = 2'b11;
        e.regfile_data_mux_sel = regfile_data_mux_sel_mdr;
        e.cc_gen_sel = cc_gen_sel_mdr; e.regfile_load = 1'b1; e.cc_load = 1'b1;
        return e;
    endfunction

    task automatic test_reset();
        reset = 1'b1; stall = 1'b1; flush = 1'b1; ir_valid = 1'b1; ir_in = 16'h1283;
        tick(); tick();
        vectors++;
        if (ir_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %b want 0", ir_ready); end
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (ctrl[k] !== '0) begin miscompares++; $display("FAIL reset_stage%0d: got %h want 0", k, ctrl[k]); end
        end
        vectors++;
        if (uop_busy !== 1'b0 || uop_index !== 1'b0) begin
            miscompares++; $display("FAIL reset_fsm: got busy=%b idx=%b want 0 0", uop_busy, uop_index);
        end
        reset = 1'b0; stall = 1'b0; flush = 1'b0; ir_valid = 1'b0;
        #1;
        vectors++;
        if (ir_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_ready: got %b want 1", ir_ready); end
    endtask

    task automatic test_add();
        lc3b_control_word e;
        e = exp_add();
        ir_in = 16'h1283; ir_valid = 1'b1;
        tick();
        ir_valid = 1'b0;
        vectors++;
        if (ctrl[0] !== e) begin miscompares++; $display("FAIL add_stage0: got %h want %h", ctrl[0], e); end
        tick();
        vectors++;
        if (ctrl[1] !== e || ctrl[0] !== '0) begin
            miscompares++; $display("FAIL add_stage1: got %h/%h want %h/0", ctrl[1], ctrl[0], e);
        end
        tick(); tick();
        vectors++;
        if (ctrl[3] !== e) begin miscompares++; $display("FAIL add_stage3: got %h want %h", ctrl[3], e); end
    endtask

    task automatic test_single_uops();
        logic [15:0]      irs  [5];
        lc3b_control_word exps [5];
        irs[0] = 16'h6283; exps[0] = fld(op_ldr, 3'd1, 3'd2, 3'd3, 6'h03);
        exps[0].alumux_sel = alumux_offset6; exps[0].data_memory_read = 1'b1;
        exps[0].data_memory_byte_sel = 2'b11; exps[0].regfile_data_mux_sel = regfile_data_mux_sel_mdr;
        exps[0].cc_gen_sel = cc_gen_sel_mdr; exps[0].regfile_load = 1'b1; exps[0].cc_load = 1'b1;
        irs[1] = 16'h7283; exps[1] = fld(op_str, 3'd1, 3'd2, 3'd3, 6'h03);
        exps[1].alumux_sel = alumux_offset6; exps[1].sr2mux_sel = sr2mux_sel_dest;
        exps[1].data_memory_write_enable = 1'b1; exps[1].data_memory_byte_sel = 2'b11;
        irs[2] = 16'h4213; exps[2] = fld(op_shf, 3'd1, 3'd0, 3'd3, 6'h13);
        exps[2].aluop = alu_srl; exps[2].alumux_sel = alumux_imm4;
        exps[2].regfile_load = 1'b1; exps[2].cc_load = 1'b1;
        irs[3] = 16'h927F; exps[3] = fld(op_not, 3'd1, 3'd1, 3'd7, 6'h3F);
        exps[3].aluop = alu_not; exps[3].regfile_load = 1'b1; exps[3].cc_load = 1'b1;
        irs[4] = 16'h5275; exps[4] = fld(op_and, 3'd1, 3'd1, 3'd5, 6'h35);
        exps[4].aluop = alu_and; exps[4].alumux_sel = alumux_imm5;
        exps[4].regfile_load = 1'b1; exps[4].cc_load = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ir_in = irs[i]; ir_valid = 1'b1;
            tick();
            ir_valid = 1'b0;
            vectors++;
            if (ctrl[0] !== exps[i] || uop_busy !== 1'b0) begin
                miscompares++;
                $display("FAIL single_%h: got %h busy=%b want %h busy=0", irs[i], ctrl[0], uop_busy, exps[i]);
            end
        end
    endtask

    task automatic test_ldi();
        drain();
        ir_in = 16'hA042; ir_valid = 1'b1;
        tick();
        ir_valid = 1'b0;
        vectors++;
        if (ir_ready !== 1'b0 || uop_busy !== 1'b1 || uop_index !== 1'b1) begin
            miscompares++; $display("FAIL ldi_c1_fsm: got rdy=%b busy=%b idx=%b want 0 1 1", ir_ready, uop_busy, uop_index);
        end
        vectors++;
        if (ctrl[0] !== exp_ind0(op_ldi)) begin miscompares++; $display("FAIL ldi_uop0: got %h want %h", ctrl[0], exp_ind0(op_ldi)); end
        vectors++;
        if (ctrl_ni[0] !== '0 || uop_busy_ni !== 1'b0 || ir_ready_ni !== 1'b1) begin
            miscompares++; $display("FAIL noind_ldi: got %h busy=%b rdy=%b want 0 0 1", ctrl_ni[0], uop_busy_ni, ir_ready_ni);
        end
        tick();
        vectors++;
        if (ctrl[0] !== exp_ldi1() || ctrl[1] !== exp_ind0(op_ldi)) begin
            miscompares++; $display("FAIL ldi_uop1: got %h/%h want %h/%h", ctrl[0], ctrl[1], exp_ldi1(), exp_ind0(op_ldi));
        end
        vectors++;
        if (ir_ready !== 1'b1 || uop_busy !== 1'b0 || uop_index !== 1'b0) begin
            miscompares++; $display("FAIL ldi_c2_fsm: got rdy=%b busy=%b idx=%b want 1 0 0", ir_ready, uop_busy, uop_index);
        end
    endtask

    task automatic test_sti_stall();
        lc3b_control_word e1;
        e1 = fld(op_sti, 3'd0, 3'd1, 3'd2, 6'h02);
        e1.data_memory_addr_mux_sel = lc3b_data_memory_addr_mux_sel_mdr;
        e1.sr2mux_sel = sr2mux_sel_dest; e1.data_memory_write_enable = 1'b1;
        e1.data_memory_byte_sel = 2'b11;
        drain();
        ir_in = 16'hB042; ir_valid = 1'b1;
        tick();
        ir_valid = 1'b0; stall = 1'b1;
        tick();
        stall = 1'b0;
        vectors++;
        if (ctrl[0] !== exp_ind0(op_sti) || ctrl[1] !== '0 || uop_index !== 1'b1) begin
            miscompares++; $display("FAIL sti_stall_hold: got %h/%h idx=%b want %h/0 idx=1", ctrl[0], ctrl[1], uop_index, exp_ind0(op_sti));
        end
        tick();
        vectors++;
        if (ctrl[0] !== e1 || ctrl[1] !== exp_ind0(op_sti) || uop_busy !== 1'b0) begin
            miscompares++; $display("FAIL sti_uop1: got %h/%h busy=%b want %h/%h busy=0", ctrl[0], ctrl[1], uop_busy, e1, exp_ind0(op_sti));
        end
    endtask

    task automatic test_flush();
        lc3b_control_word eb;
        eb = fld(op_br, 3'd7, 3'd0, 3'd5, 6'h05);
        eb.branch_enable = 1'b1;
        drain();
        ir_in = 16'h0E05; ir_valid = 1'b1;
        tick();
        ir_in = 16'hA042;
        tick();
        vectors++;
        if (ctrl[0] !== exp_ind0(op_ldi) || ctrl[1] !== eb) begin
            miscompares++; $display("FAIL flush_pre: got %h/%h want %h/%h", ctrl[0], ctrl[1], exp_ind0(op_ldi), eb);
        end
        flush = 1'b1; ir_in = 16'h1283; ir_valid = 1'b1;
        tick();
        flush = 1'b0; ir_valid = 1'b0;
        vectors++;
        if (ctrl[0] !== '0 || ctrl[1] !== '0 || ctrl[2] !== eb) begin
            miscompares++; $display("FAIL flush_stages: got %h/%h/%h want 0/0/%h", ctrl[0], ctrl[1], ctrl[2], eb);
        end
        vectors++;
        if (uop_busy !== 1'b0 || ir_ready !== 1'b1 || uop_index !== 1'b0) begin
            miscompares++; $display("FAIL flush_fsm: got busy=%b rdy=%b idx=%b want 0 1 0", uop_busy, ir_ready, uop_index);
        end
        tick();
        vectors++;
        if (ctrl[0] !== '0 || ctrl[3] !== eb) begin
            miscompares++; $display("FAIL flush_no_uop1: got %h/%h want 0/%h", ctrl[0], ctrl[3], eb);
        end
    endtask

    task automatic test_back_to_back();
        lc3b_control_word ea;
        ea = exp_add();
        drain();
        ir_valid = 1'b1;
        ir_in = 16'h1283; tick();
        ir_in = 16'h927F; tick();
        ir_in = 16'h5275; tick();
        ir_valid = 1'b0;
        vectors++;
        if (ctrl[2] !== ea || ctrl[1].opcode !== op_not || ctrl[0].opcode !== op_and) begin
            miscompares++; $display("FAIL b2b_fill: got %h/%h/%h want ADD/NOT/AND", ctrl[2], ctrl[1], ctrl[0]);
        end
        flush = 1'b1; stall = 1'b1;
        tick();
        flush = 1'b0; stall = 1'b0;
        vectors++;
        if (ctrl[0] !== '0 || ctrl[1] !== '0 || ctrl[2] !== ea || ctrl[3] !== '0) begin
            miscompares++; $display("FAIL flush_stall: got %h/%h/%h/%h want 0/0/%h/0", ctrl[0], ctrl[1], ctrl[2], ctrl[3], ea);
        end
    endtask

    task automatic test_reset_mid_seq();
        drain();
        ir_in = 16'hA042; ir_valid = 1'b1;
        tick();
        ir_valid = 1'b0; reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if (ctrl[0] !== '0 || ctrl[1] !== '0 || uop_busy !== 1'b0 || uop_index !== 1'b0) begin
            miscompares++; $display("FAIL rst_seq: got %h/%h busy=%b idx=%b want 0/0 0 0", ctrl[0], ctrl[1], uop_busy, uop_index);
        end
        #1;
        vectors++;
        if (ir_ready !== 1'b1) begin miscompares++; $display("FAIL rst_seq_ready: got %b want 1", ir_ready); end
        tick();
        vectors++;
        if (ctrl[0] !== '0 || ctrl[1] !== '0) begin
            miscompares++; $display("FAIL rst_seq_no_uop1: got %h/%h want 0/0", ctrl[0], ctrl[1]);
        end
    endtask

    task automatic test_unknown();
        drain();
        ir_in = 16'hD123; ir_valid = 1'b1;
        tick();
        ir_valid = 1'b0;
        vectors++;
        if (ctrl[0] !== '0 || uop_busy !== 1'b0 || ir_ready !== 1'b1) begin
            miscompares++; $display("FAIL unknown_op: got %h busy=%b rdy=%b want 0 0 1", ctrl[0], uop_busy, ir_ready);
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; ir_valid = 1'b0; ir_in = '0;
        test_reset();
        test_add();
        test_single_uops();
        test_ldi();
        test_sti_stall();
        test_flush();
        test_back_to_back();
        test_reset_mid_seq();
        test_unknown();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
